// File: rtl/fifo_defs_pkg.sv
// Shared definitions for the show-ahead FIFO (fifo_fwft) and its RAM (fifo_dpram).
// Optional feature macro: FIFO_ERR_FLAGS_EN -- when defined, fifo_fwft gains sticky
// overflow/underflow outputs; when undefined, illegal requests are silently ignored.
package fifo_defs_pkg;

  localparam int unsigned DefDataWidth   = 8;
  localparam int unsigned DefAddrWidth   = 4;
  localparam int unsigned DefAemptyLevel = 1;

  // Pointers and the element count carry one extra bit so all 2^addr_width slots are usable.
  function automatic int unsigned cnt_width(int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: one write port, one synchronous read port, read-before-write on a
// same-address collision. The array itself is never reset; only the read register is.
module fifo_dpram
  import fifo_defs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Storage array write; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; non-blocking semantics return the old word on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_fwft.sv
// Single-clock, block-RAM backed show-ahead FIFO with registered status flags.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module fifo_fwft
  import fifo_defs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned AFULL_LEVEL  = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AEMPTY_LEVEL = DefAemptyLevel
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   elemcnt
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam int unsigned CntW  = cnt_width(ADDR_WIDTH);

  localparam logic [CntW-1:0] AfullLvl  = CntW'(AFULL_LEVEL);
  localparam logic [CntW-1:0] AemptyLvl = CntW'(AEMPTY_LEVEL);

  if (AFULL_LEVEL > Depth) begin : g_bad_afull
    $error("fifo_fwft: AFULL_LEVEL must not exceed the depth");
  end
  if (AEMPTY_LEVEL >= Depth) begin : g_bad_aempty
    $error("fifo_fwft: AEMPTY_LEVEL must be below the depth");
  end

  logic [CntW-1:0]       wrptr_q, wrptr_d;
  logic [CntW-1:0]       rdptr_q, rdptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  wa, pa;
  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;

  // Accept/pop decisions and next-state for pointers, count and flags.
  always_comb begin
    wa      = wr_en & ~full_q;
    pa      = rd_en & ~empty_q;
    wrptr_d = wrptr_q + CntW'(wa);
    rdptr_d = rdptr_q + CntW'(pa);
    count_d = count_q + CntW'(wa) - CntW'(pa);
    full_d  = (wrptr_d[ADDR_WIDTH-1:0] == rdptr_d[ADDR_WIDTH-1:0]) &&
              (wrptr_d[ADDR_WIDTH] != rdptr_d[ADDR_WIDTH]);
    // A word written at this edge is not yet readable from the RAM, so it does not count.
    empty_d  = ((count_d - CntW'(wa)) == '0);
    afull_d  = (count_d >= AfullLvl);
    aempty_d = (count_d <= AemptyLvl);
  end

  // RAM port control: fetch the next head on a pop, or the parked head while it is not shown.
  always_comb begin
    ram_we    = wa & ~clr;
    ram_raddr = rdptr_d[ADDR_WIDTH-1:0];
    // Skip the fetch when a pop drains the last word so dout simply holds.
    ram_re    = (pa & (count_q > CntW'(1))) | (empty_q & (count_q != '0));
  end

  // Pointer, count and flag registers; clr outranks any same-cycle request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrptr_q  <= '0;
      rdptr_q  <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else if (clr) begin
      wrptr_q  <= '0;
      rdptr_q  <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wrptr_q  <= wrptr_d;
      rdptr_q  <= rdptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  fifo_dpram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .wr_en  (ram_we),
    .wr_addr(wrptr_q[ADDR_WIDTH-1:0]),
    .wr_data(din),
    .rd_en  (ram_re),
    .rd_addr(ram_raddr),
    .rd_data(dout)
  );

  assign full         = full_q;
  assign almost_full  = afull_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign elemcnt      = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags, raised on any rejected request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (wr_en & full_q);
      underflow_q <= underflow_q | (rd_en & empty_q);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_fwft.sv
// Directed/randomized bench for fifo_fwft against a queue-based reference model.
// Model rule: a written word becomes readable one edge after it is written.
module tb_fifo_fwft;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 14;
  localparam int AEL   = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic [DW-1:0] din;
  logic          wr_en;
  logic          full;
  logic          almost_full;
  logic [DW-1:0] dout;
  logic          rd_en;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   elemcnt;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  always #5 clk = ~clk;

  fifo_fwft #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .AFULL_LEVEL (AFL),
    .AEMPTY_LEVEL(AEL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .din         (din),
    .wr_en       (wr_en),
    .full        (full),
    .almost_full (almost_full),
    .dout        (dout),
    .rd_en       (rd_en),
    .empty       (empty),
    .almost_empty(almost_empty),
    .elemcnt     (elemcnt)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    int            stamp;
  } ent_t;

  ent_t q[$];
  int   edge_n = 0;
  bit   m_empty = 1'b1;
  bit   m_ovf = 1'b0;
  bit   m_unf = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":empty"}, 32'(empty), 32'(m_empty));
    chk({tag, ":elemcnt"}, 32'(elemcnt), n);
    chk({tag, ":full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ":almost_full"}, 32'(almost_full), 32'(n >= AFL));
    chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(n <= AEL));
    if (!m_empty) chk({tag, ":dout"}, 32'(dout), 32'(q[0].data));
`ifdef FIFO_ERR_FLAGS_EN
    chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ":underflow"}, 32'(underflow), 32'(m_unf));
`endif
  endtask

  // One clock of stimulus: drive, advance the model, clock, sample 1 time unit later.
  task automatic step(input string tag, input bit w, input bit r, input logic [DW-1:0] d,
                      input bit c = 1'b0);
    bit full_pre;
    full_pre = (q.size() == DEPTH);
    wr_en = w;
    rd_en = r;
    din   = d;
    clr   = c;
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && full_pre) m_ovf = 1'b1;
      if (r && m_empty) m_unf = 1'b1;
      if (r && !m_empty) q.delete(0);
      if (w && !full_pre) q.push_back('{data: d, stamp: edge_n + 1});
    end
    edge_n++;
    m_empty = (q.size() == 0) || (q[0].stamp == edge_n);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
    check_all(tag);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_empty = 1'b1;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    check_all(tag);
    chk({tag, ":dout_zero"}, 32'(dout), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset:dout_zero", 32'(dout), 32'h0);
    rst_n = 1'b1;

    // Mid-stream reset with five words stored, then a single write.
    for (int i = 0; i < 5; i++) step("pre_rst_wr", 1'b1, 1'b0, DW'($urandom));
    async_reset("mid_reset");
    step("post_rst_idle", 1'b0, 1'b0, '0);
    chk("post_rst:dout_zero", 32'(dout), 32'h0);
    step("a5_edge1", 1'b1, 1'b0, 8'hA5);
    chk("a5_edge1:still_empty", 32'(empty), 32'h1);
    step("a5_edge2", 1'b0, 1'b0, '0);
    chk("a5_edge2:dout", 32'(dout), 32'hA5);
    step("a5_pop", 1'b0, 1'b1, '0);

    // Fill to full, attempt one extra write, then drain in order with no bubbles.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, DW'(i));
    chk("fill:full", 32'(full), 32'h1);
    step("fill_extra", 1'b1, 1'b0, 8'hEE);
    chk("fill_extra:elemcnt", 32'(elemcnt), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_seq", 32'(dout), 32'(i));
      chk("drain_valid", 32'(empty), 32'h0);
      step("drain", 1'b0, 1'b1, '0);
    end
    chk("drain:empty", 32'(empty), 32'h1);

    // Streaming at count 3: simultaneous write and pop every cycle.
    for (int i = 0; i < 3; i++) step("stream_pre", 1'b1, 1'b0, DW'($urandom));
    step("stream_settle", 1'b0, 1'b0, '0);
    for (int i = 0; i < 100; i++) begin
      step("stream", 1'b1, 1'b1, DW'($urandom));
      chk("stream:elemcnt3", 32'(elemcnt), 32'h3);
    end

    // Pop and write at count 1 in the same cycle.
    step("bnd_pop1", 1'b0, 1'b1, '0);
    step("bnd_pop2", 1'b0, 1'b1, '0);
    chk("bnd:count1", 32'(elemcnt), 32'h1);
    step("bnd_both", 1'b1, 1'b1, 8'h55);
    chk("bnd_both:empty", 32'(empty), 32'h1);
    chk("bnd_both:elemcnt", 32'(elemcnt), 32'h1);
    step("bnd_after", 1'b0, 1'b0, '0);
    chk("bnd_after:empty", 32'(empty), 32'h0);
    chk("bnd_after:dout", 32'(dout), 32'h55);
    chk("bnd_after:elemcnt", 32'(elemcnt), 32'h1);

    // Random traffic pushing many words through to exercise pointer wrap.
    for (int i = 0; i < 200; i++) begin
      step("wrap_rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
           DW'($urandom));
    end

    // clr together with wr_en: contents dropped and the write discarded.
    step("clr_wr", 1'b1, 1'b0, 8'h77, 1'b1);
    chk("clr_wr:elemcnt", 32'(elemcnt), 32'h0);
    step("clr_idle", 1'b0, 1'b0, '0);
    chk("clr_idle:empty", 32'(empty), 32'h1);

`ifdef FIFO_ERR_FLAGS_EN
    step("unf_rd", 1'b0, 1'b1, '0);
    chk("unf_rd:underflow", 32'(underflow), 32'h1);
    step("unf_hold", 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) step("ovf_fill", 1'b1, 1'b0, DW'($urandom));
    chk("ovf_fill:overflow_clear", 32'(overflow), 32'h0);
    step("ovf_wr", 1'b1, 1'b0, 8'h99);
    chk("ovf_wr:overflow", 32'(overflow), 32'h1);
    step("err_clr", 1'b0, 1'b0, '0, 1'b1);
    chk("err_clr:overflow", 32'(overflow), 32'h0);
    chk("err_clr:underflow", 32'(underflow), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
